// File: rtl/modinv_arbiter.sv
// Round-robin arbiter sharing one ModInvert engine among NUM_REQ requesters.
// One operation in flight; zero modulus is answered locally with rsp_err.
module modinv_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 256,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_base,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_mod,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_res,
    output logic                          rsp_err,
    output logic                          eng_din_valid,
    input  logic                          eng_din_ready,
    output logic [DATA_WIDTH-1:0]         eng_din_base,
    output logic [DATA_WIDTH-1:0]         eng_din_mod,
    input  logic                          eng_dout_valid,
    output logic                          eng_dout_ready,
    input  logic [DATA_WIDTH-1:0]         eng_dout_res,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic [CNT_WIDTH-1:0]          ops_done
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = IW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, DELIVER} state_e;

    state_e                state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic [CNT_WIDTH-1:0]  ops_q, ops_d;
    logic [DATA_WIDTH-1:0] base_q, base_d;
    logic [DATA_WIDTH-1:0] mod_q, mod_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  err_q, err_d;

    logic                  win_found;
    logic [IW-1:0]         win_idx;
    logic [SW-1:0]         scan;
    logic [DATA_WIDTH-1:0] lane_base;
    logic [DATA_WIDTH-1:0] lane_mod;

    // Scan ptr, ptr+1, ... modulo NUM_REQ; first valid requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, ptr_q} + SW'(k);
            if (scan >= SW'(NUM_REQ)) begin
                scan = scan - SW'(NUM_REQ);
            end
            if (!win_found && req_valid[scan[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[IW-1:0];
            end
        end
    end

    assign lane_base = req_base[win_idx*DATA_WIDTH +: DATA_WIDTH];
    assign lane_mod  = req_mod[win_idx*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            ops_q   <= '0;
            base_q  <= '0;
            mod_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            ops_q   <= ops_d;
            base_q  <= base_d;
            mod_q   <= mod_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = (lane_mod == '0) ? DELIVER : ISSUE;
                end
            end
            ISSUE:    if (eng_din_ready)      state_d = WAIT_RES;
            WAIT_RES: if (eng_dout_valid)     state_d = DELIVER;
            DELIVER:  if (rsp_ready[owner_q]) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = '0;
        rsp_valid      = '0;
        eng_din_valid  = 1'b0;
        eng_dout_ready = 1'b0;
        unique case (state_q)
            IDLE:     if (win_found) req_ready[win_idx] = 1'b1;
            ISSUE:    eng_din_valid  = 1'b1;
            WAIT_RES: eng_dout_ready = 1'b1;
            DELIVER:  rsp_valid[owner_q] = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        owner_d = owner_q;
        ops_d   = ops_q;
        base_d  = base_q;
        mod_d   = mod_q;
        res_d   = res_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    owner_d = win_idx;
                    base_d  = lane_base;
                    mod_d   = lane_mod;
                    if (lane_mod == '0) begin
                        res_d = '0;
                        err_d = 1'b1;
                    end
                end
            end
            WAIT_RES: begin
                if (eng_dout_valid) begin
                    res_d = eng_dout_res;
                    err_d = 1'b0;
                end
            end
            DELIVER: begin
                if (rsp_ready[owner_q]) begin
                    ops_d = ops_q + 1'b1;
                    ptr_d = (owner_q == IW'(NUM_REQ - 1)) ? '0
                                                         : owner_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign eng_din_base = base_q;
    assign eng_din_mod  = mod_q;
    assign rsp_res      = res_q;
    assign rsp_err      = err_q;
    assign busy         = (state_q != IDLE);
    assign owner        = owner_q;
    assign ops_done     = ops_q;
endmodule

// File: tb/tb_modinv_arbiter.sv
// Scoreboard bench for modinv_arbiter with a behavioural ModInvert engine.
// Drives on negedge, judges each upcoming posedge from settled values.
module tb_modinv_arbiter;
    localparam int N  = 2;
    localparam int DW = 16;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*DW-1:0]   req_base, req_mod;
    logic [DW-1:0]     rsp_res, eng_din_base, eng_din_mod, eng_dout_res;
    logic              rsp_err, eng_din_valid, eng_din_ready;
    logic              eng_dout_valid, eng_dout_ready, busy;
    logic [0:0]        owner;
    logic [CW-1:0]     ops_done;

    always #5 clk = ~clk;

    modinv_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_base(req_base), .req_mod(req_mod),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_err(rsp_err),
        .eng_din_valid(eng_din_valid), .eng_din_ready(eng_din_ready),
        .eng_din_base(eng_din_base), .eng_din_mod(eng_din_mod),
        .eng_dout_valid(eng_dout_valid), .eng_dout_ready(eng_dout_ready),
        .eng_dout_res(eng_dout_res),
        .busy(busy), .owner(owner), .ops_done(ops_done)
    );

    typedef struct {
        int          own;
        logic [DW-1:0] base, mod, res;
        bit          err;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   n_chk = 0, n_fail = 0, cyc = 0;
    bit   m_busy = 0, after_rst = 0;
    int   m_ptr = 0, m_ops = 0, m_dinc = 0, w;

    bit [N-1:0]    lane_pend = '0;
    logic [DW-1:0] lane_b[N], lane_m[N];
    int            lane_rep[N];
    bit            gen_en = 0, rnd_rsp = 0, rnd_eng = 0;
    int            din_stall = 0, rsp_hold_req = 0, hold_cnt = 0;
    int            e_lat_force = 0;
    logic [N-1:0]  acc = '0;

    // Modular inverse by extended Euclid; 0 when none exists.
    function automatic logic [DW-1:0] minv(input logic [DW-1:0] a,
                                           input logic [DW-1:0] m);
        longint t, nt, r, nr, q, tmp;
        if (m == 0) return '0;
        t = 0; nt = 1; r = m; nr = a % m;
        while (nr != 0) begin
            q = r / nr;
            tmp = t - q * nt; t = nt; nt = tmp;
            tmp = r - q * nr; r = nr; nr = tmp;
        end
        if (r > 1) return '0;
        if (t < 0) t = t + m;
        return DW'(t);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic fail_to(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    task automatic new_op(input int i);
        int r;
        r = $urandom_range(0, 7);
        lane_b[i] = DW'($urandom);
        if (r == 0)     lane_m[i] = '0;
        else if (r < 4) lane_m[i] = DW'($urandom_range(1, 40));
        else            lane_m[i] = DW'($urandom);
    endtask

    task automatic send(input int i, input logic [DW-1:0] b,
                        input logic [DW-1:0] m);
        lane_b[i] = b;
        lane_m[i] = m;
        lane_pend[i] = 1'b1;
    endtask

    task automatic wait_done(input int max);
        for (int k = 0; k < max; k++) begin
            @(posedge clk); #2;
            if (lane_pend == '0 && !m_busy) return;
        end
        fail_to("wait_done");
    endtask

    // Requester lanes and response acceptance.
    initial begin
        req_valid = '0; req_base = '0; req_mod = '0; rsp_ready = '0;
        for (int i = 0; i < N; i++) begin
            lane_rep[i] = 0; lane_b[i] = '0; lane_m[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    if (lane_rep[i] > 0) begin
                        lane_rep[i]--;
                        new_op(i);
                    end else lane_pend[i] = 1'b0;
                end
                if (gen_en) begin
                    if (!lane_pend[i] && $urandom_range(0, 3) == 0) begin
                        new_op(i);
                        lane_pend[i] = 1'b1;
                    end else if (lane_pend[i] && $urandom_range(0, 15) == 0)
                        lane_pend[i] = 1'b0;
                end
            end
            for (int i = 0; i < N; i++) begin
                req_valid[i] = lane_pend[i];
                req_base[i*DW +: DW] = lane_pend[i] ? lane_b[i] : DW'($urandom);
                req_mod[i*DW +: DW]  = lane_pend[i] ? lane_m[i] : DW'($urandom);
            end
            if (hold_cnt == 0 && rsp_hold_req > 0 && rsp_valid != '0) begin
                hold_cnt = rsp_hold_req;
                rsp_hold_req = 0;
            end
            if (hold_cnt > 0) begin
                rsp_ready = '0;
                hold_cnt--;
            end else rsp_ready = rnd_rsp ? N'($urandom) : '1;
            #1;
            acc = rst ? '0 : (req_valid & req_ready);
        end
    end

    // Behavioural engine: one job, variable latency.
    initial begin
        bit e_full, din_fire, dout_fire;
        int e_lat;
        logic [DW-1:0] e_res, c_base, c_mod;
        e_full = 0; din_fire = 0; dout_fire = 0; e_lat = 0;
        e_res = '0; c_base = '0; c_mod = '0;
        eng_din_ready = 1'b0; eng_dout_valid = 1'b0; eng_dout_res = '0;
        forever begin
            @(negedge clk);
            if (dout_fire) e_full = 0;
            if (din_fire) begin
                e_full = 1;
                e_res  = minv(c_base, c_mod);
                e_lat  = e_lat_force > 0 ? e_lat_force
                       : (rnd_eng ? $urandom_range(0, 3) : 0);
            end else if (e_full && e_lat > 0) e_lat--;
            if (e_full) eng_din_ready = 1'b0;
            else if (din_stall > 0 && eng_din_valid) begin
                eng_din_ready = 1'b0;
                din_stall--;
            end else eng_din_ready = rnd_eng ? ($urandom_range(0, 3) != 0) : 1'b1;
            eng_dout_valid = e_full && e_lat == 0;
            eng_dout_res   = eng_dout_valid ? e_res : DW'($urandom);
            #1;
            din_fire  = eng_din_valid && eng_din_ready;
            dout_fire = eng_dout_valid && eng_dout_ready;
            c_base = eng_din_base;
            c_mod  = eng_din_mod;
            if (rst) begin
                din_fire = 0; dout_fire = 0; e_full = 0;
            end
        end
    end

    // Reference model and scoreboard monitor.
    initial begin
        forever begin
            @(negedge clk); #2;
            cyc++;
            if (rst) begin
                sbq.delete();
                m_busy = 0; m_ptr = 0; m_ops = 0; after_rst = 1;
            end else begin
                chk("busy", busy, m_busy);
                chk("ops_done", ops_done, m_ops % (1 << CW));
                chk("eng_excl", eng_din_valid & eng_dout_ready, 0);
                if (after_rst) begin
                    chk("rst_res", rsp_res, 0);
                    chk("rst_err", rsp_err, 0);
                    chk("rst_owner", owner, 0);
                end
                if (!m_busy) begin
                    chk("idle_din_valid", eng_din_valid, 0);
                    chk("idle_dout_ready", eng_dout_ready, 0);
                    chk("idle_rsp_valid", rsp_valid, 0);
                    if (req_valid != '0) begin
                        w = pick(req_valid, m_ptr);
                        chk("grant", req_ready, 1 << w);
                        e.own  = w;
                        e.base = req_base[w*DW +: DW];
                        e.mod  = req_mod[w*DW +: DW];
                        e.err  = (e.mod == '0);
                        e.res  = e.err ? '0 : minv(e.base, e.mod);
                        e.acc  = cyc;
                        sbq.push_back(e);
                        m_busy = 1; m_dinc = 0; after_rst = 0;
                    end else chk("no_grant", req_ready, 0);
                end else if (sbq.size() > 0) begin
                    e = sbq[0];
                    chk("busy_no_grant", req_ready, 0);
                    chk("owner", owner, e.own);
                    if (e.err) begin
                        chk("err_no_eng", eng_din_valid | eng_dout_ready, 0);
                        chk("err_rsp_now", rsp_valid, 1 << e.own);
                    end
                    if (eng_din_valid) begin
                        chk("din_base", eng_din_base, e.base);
                        chk("din_mod", eng_din_mod, e.mod);
                    end
                    if (eng_din_valid && eng_din_ready) m_dinc++;
                    if (rsp_valid != '0) begin
                        chk("rsp_onehot", rsp_valid, 1 << e.own);
                        chk("rsp_res", rsp_res, e.res);
                        chk("rsp_err", rsp_err, e.err);
                        chk("eng_ops", m_dinc, e.err ? 0 : 1);
                        if (!e.err) chk("min_lat", (cyc - e.acc) >= 3, 1);
                        if (rsp_ready[e.own]) begin
                            void'(sbq.pop_front());
                            m_ops++;
                            m_ptr = (e.own + 1) % N;
                            m_busy = 0;
                        end
                    end else if (cyc - e.acc > 400) begin
                        fail_to("op_latency");
                        sbq.delete();
                        m_busy = 0;
                    end
                end
            end
        end
    end

    initial begin
        bit seen;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        send(0, 16'd3, 16'd11);
        wait_done(100);

        send(0, DW'($urandom), 16'd65521);
        send(1, DW'($urandom), 16'd97);
        lane_rep[0] = 1; lane_rep[1] = 1;
        wait_done(300);

        send(1, DW'($urandom), 16'd0);
        wait_done(100);

        din_stall = 5; rsp_hold_req = 3;
        send(0, 16'hBEEF, 16'd65521);
        send(1, 16'd77, 16'd101);
        wait_done(300);

        rnd_eng = 1; rnd_rsp = 1; gen_en = 1;
        repeat (3000) @(posedge clk);
        #2 gen_en = 0;
        wait_done(1000);

        rnd_eng = 0; rnd_rsp = 0;
        send(0, 16'd3, 16'd11);
        wait_done(100);
        e_lat_force = 20;
        send(0, 16'd5, 16'd13);
        seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(posedge clk); #2;
            seen = eng_dout_ready;
        end
        if (!seen) fail_to("reach_wait_res");
        rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        e_lat_force = 0;
        send(0, 16'd9, 16'd13);
        send(1, 16'd2, 16'd7);
        wait_done(200);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
